trng_health_monitor: RTL

//  Parametrised continuous health-test stage for the TRNG raw bit stream (SP 800-90B style).

---
 rtl/trng_health_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/trng_health_monitor.sv
// Continuous health tests (repetition count + adaptive proportion) on the raw TRNG bit stream.
// Healthy bits are forwarded downstream only after a failure-free startup period.
module trng_health_monitor #(
    parameter int unsigned RCT_CUTOFF      = 32,
    parameter int unsigned APT_WINDOW      = 1024,
    parameter int unsigned APT_CUTOFF      = 589,
    parameter int unsigned STARTUP_WINDOWS = 1,
    parameter int unsigned FAIL_LATCH      = 1
) (
    input  logic       TRNG_Clock,
    input  logic       TRNG_Enable,
    input  logic       Sample_In,
    input  logic       Sample_Valid,
    input  logic       clear_fail,
    output logic       Bit_Out,
    output logic       Bit_Valid,
    output logic       startup_done,
    output logic       rct_fail,
    output logic       apt_fail,
    output logic       failure,
    output logic [7:0] fail_count
);

    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);
    localparam int unsigned STW   = $clog2(STARTUP_WINDOWS + 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             rct_seen_q;
    logic             rct_last_q;
    logic [RCT_W-1:0] rct_run_q;
    logic [RCT_W-1:0] rct_run_d;
    logic [APT_W-1:0] apt_pos_q;
    logic [APT_W-1:0] apt_pos_d;
    logic [APT_W-1:0] apt_match_q;
    logic [APT_W-1:0] apt_match_d;
    logic             apt_ref_q;
    logic             apt_ref_d;
    logic [STW-1:0]   st_cnt_q;

    logic sample_act;
    logic new_win;
    logic rct_hit;
    logic apt_hit;
    logic fail_hit;
    logic win_done;
    logic startup_pass;
    logic forward;

    // Test arithmetic for the sample presented this cycle
    always_comb begin
        sample_act  = Sample_Valid && (state_q != ST_FAIL);
        rct_run_d   = RCT_W'(1);
        apt_pos_d   = APT_W'(1);
        apt_match_d = APT_W'(1);
        apt_ref_d   = Sample_In;
        new_win     = (apt_pos_q == '0) || (apt_pos_q == APT_W'(APT_WINDOW));

        if (rct_seen_q && (Sample_In == rct_last_q)) begin
            rct_run_d = rct_run_q + RCT_W'(1);
        end

        if (!new_win) begin
            apt_pos_d   = apt_pos_q + APT_W'(1);
            apt_ref_d   = apt_ref_q;
            apt_match_d = apt_match_q + APT_W'(Sample_In == apt_ref_q);
        end

        rct_hit      = sample_act && (rct_run_d == RCT_W'(RCT_CUTOFF));
        apt_hit      = sample_act && (apt_match_d == APT_W'(APT_CUTOFF));
        fail_hit     = rct_hit || apt_hit;
        win_done     = sample_act && !fail_hit && (apt_pos_d == APT_W'(APT_WINDOW));
        startup_pass = (state_q == ST_STARTUP) && win_done
                       && (st_cnt_q == STW'(STARTUP_WINDOWS - 1));
        forward      = sample_act && !fail_hit && (state_q == ST_RUN);
    end

    always_ff @(posedge TRNG_Clock) begin
        if (!TRNG_Enable) begin
            state_q <= ST_STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a failure always takes priority over passing startup or clearing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STARTUP: begin
                if (fail_hit) begin
                    state_d = ST_FAIL;
                end else if (startup_pass) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fail_hit) begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if ((FAIL_LATCH == 0) || clear_fail) begin
                    state_d = ST_STARTUP;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge TRNG_Clock) begin
        if (!TRNG_Enable) begin
            rct_seen_q   <= 1'b0;
            rct_last_q   <= 1'b0;
            rct_run_q    <= '0;
            apt_pos_q    <= '0;
            apt_match_q  <= '0;
            apt_ref_q    <= 1'b0;
            st_cnt_q     <= '0;
            Bit_Out      <= 1'b0;
            Bit_Valid    <= 1'b0;
            startup_done <= 1'b0;
            rct_fail     <= 1'b0;
            apt_fail     <= 1'b0;
            failure      <= 1'b0;
            fail_count   <= 8'd0;
        end else begin
            Bit_Valid    <= forward;
            startup_done <= (state_d == ST_RUN);
            if (forward) begin
                Bit_Out <= Sample_In;
            end

            // Test history is wiped while in FAIL so startup restarts from scratch
            if (state_q == ST_FAIL) begin
                rct_seen_q  <= 1'b0;
                rct_last_q  <= 1'b0;
                rct_run_q   <= '0;
                apt_pos_q   <= '0;
                apt_match_q <= '0;
                apt_ref_q   <= 1'b0;
                st_cnt_q    <= '0;
            end else if (sample_act) begin
                rct_seen_q  <= 1'b1;
                rct_last_q  <= Sample_In;
                rct_run_q   <= rct_run_d;
                apt_pos_q   <= apt_pos_d;
                apt_match_q <= apt_match_d;
                apt_ref_q   <= apt_ref_d;
                if (win_done && (state_q == ST_STARTUP)) begin
                    st_cnt_q <= st_cnt_q + STW'(1);
                end
            end

            // Flags latch until cleared, or pulse for one cycle in auto-restart mode
            if (fail_hit) begin
                rct_fail <= rct_hit;
                apt_fail <= apt_hit;
                failure  <= 1'b1;
                if (fail_count != 8'hFF) begin
                    fail_count <= fail_count + 8'd1;
                end
            end else if ((FAIL_LATCH == 0) || ((state_q == ST_FAIL) && clear_fail)) begin
                rct_fail <= 1'b0;
                apt_fail <= 1'b0;
                failure  <= 1'b0;
            end
        end
    end

endmodule
